// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit one-hot-selected ALU with valid/ready handshakes on
// both sides and a registered result that is held until it is consumed.
// Single-cycle ops finish one cycle after accept. MUL is an optional
// shift-add multiplier that takes WIDTH extra cycles and is only built
// when the macro ALU_SEQ_MUL_EN is defined. Without it, selector bit 9
// is reported as an unsupported code.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SEL_W-1:0]   selector,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] result_hi,
    output logic [WIDTH/2-1:0] result_lo,
    output logic               negative,
    output logic               zero,
    output logic               carry,
    output logic               error
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] SEL_ADD  = SEL_ONE << 0;
    localparam logic [SEL_W-1:0] SEL_SUB  = SEL_ONE << 1;
    localparam logic [SEL_W-1:0] SEL_NOT  = SEL_ONE << 2;
    localparam logic [SEL_W-1:0] SEL_NAND = SEL_ONE << 3;
    localparam logic [SEL_W-1:0] SEL_NOR  = SEL_ONE << 4;
    localparam logic [SEL_W-1:0] SEL_AND  = SEL_ONE << 5;
    localparam logic [SEL_W-1:0] SEL_XOR  = SEL_ONE << 6;
    localparam logic [SEL_W-1:0] SEL_OR   = SEL_ONE << 7;
    localparam logic [SEL_W-1:0] SEL_XNOR = SEL_ONE << 8;
    localparam logic [SEL_W-1:0] SEL_MUL  = SEL_ONE << 9;
    localparam logic [SEL_W-1:0] SEL_SHL  = SEL_ONE << 10;
    localparam logic [SEL_W-1:0] SEL_SHR  = SEL_ONE << 11;

    // Bits 0..11 are decodable. The subtraction yields all-ones when SEL_W
    // is exactly 12 because the shift then wraps to zero.
    localparam logic [SEL_W-1:0] SEL_ALL  = (SEL_ONE << 12) - SEL_ONE;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [SEL_W-1:0] SUP_MASK = SEL_ALL;
`else
    localparam logic [SEL_W-1:0] SUP_MASK = SEL_ALL & ~SEL_MUL;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_result;
    logic               r_negative;
    logic               r_zero;
    logic               r_carry;
    logic               r_error;

    logic [WIDTH:0]     w_sum;
    logic [SH_W-1:0]    w_shamt;
    logic               w_err;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_neg;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [SH_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == SH_W'(WIDTH-1));
`endif

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_shamt = b[SH_W-1:0];
    assign w_err   = !$onehot(selector) || ((selector & ~SUP_MASK) != {SEL_W{1'b0}});

`ifdef ALU_SEQ_MUL_EN
    assign w_is_mul = !w_err && (selector == SEL_MUL);
`else
    assign w_is_mul = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result_hi = r_result[WIDTH-1:WIDTH/2];
    assign result_lo = r_result[WIDTH/2-1:0];
    assign negative  = r_negative;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign error     = r_error;

    // Single-cycle datapath: result and flags for every non-MUL opcode.
    always_comb begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_neg   = 1'b0;
        if (w_err) begin
            w_res = {WIDTH{1'b0}};
        end else begin
            case (selector)
                SEL_ADD: begin
                    w_res   = w_sum[WIDTH-1:0];
                    w_carry = w_sum[WIDTH];
                end
                SEL_SUB: begin
                    // Magnitude of the difference; equal operands count as negative.
                    if (a > b) begin
                        w_res = a - b;
                        w_neg = 1'b0;
                    end else begin
                        w_res = b - a;
                        w_neg = 1'b1;
                    end
                end
                SEL_NOT:  w_res = ~a;
                SEL_NAND: w_res = ~(a & b);
                SEL_NOR:  w_res = ~(a | b);
                SEL_AND:  w_res = a & b;
                SEL_XOR:  w_res = a ^ b;
                SEL_OR:   w_res = a | b;
                SEL_XNOR: w_res = ~(a ^ b);
                SEL_SHL:  w_res = a << w_shamt;
                SEL_SHR:  w_res = a >> w_shamt;
                default:  w_res = {WIDTH{1'b0}};
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = w_is_mul ? BUSY : DONE;
                end else begin
                    w_state_next = IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (w_mul_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = BUSY;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Result and flag registers: loaded at accept or at the end of a multiply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result   <= {WIDTH{1'b0}};
            r_negative <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && w_is_mul) begin
                        r_result   <= {WIDTH{1'b0}};
                        r_negative <= 1'b0;
                        r_zero     <= 1'b0;
                        r_carry    <= 1'b0;
                        r_error    <= 1'b0;
                    end else if (in_valid) begin
                        r_result   <= w_res;
                        r_negative <= w_neg;
                        r_zero     <= !w_err && (w_res == {WIDTH{1'b0}});
                        r_carry    <= w_carry;
                        r_error    <= w_err;
                    end else begin
                        r_result <= r_result;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                BUSY: begin
                    if (w_mul_last) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_zero   <= (w_acc_next[WIDTH-1:0] == {WIDTH{1'b0}});
                        r_carry  <= (w_acc_next[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    end else begin
                        r_result <= r_result;
                    end
                end
`endif
                default: r_result <= r_result;
            endcase
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: one bit of b per cycle, LSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {SH_W{1'b0}};
        end else if ((r_state == IDLE) && in_valid && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {SH_W{1'b0}};
        end else if (r_state == BUSY) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + SH_W'(1);
        end else begin
            r_cnt    <= r_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8). The stimulus pushes expected
// results into a queue. A monitor pops one entry and compares it each time
// a result is consumed.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] selector;
    logic          out_valid;
    logic          out_ready;
    logic [W/2-1:0] result_hi;
    logic [W/2-1:0] result_lo;
    logic          negative;
    logic          zero;
    logic          carry;
    logic          error;

    typedef struct packed {
        logic [7:0] res;
        logic       neg;
        logic       zr;
        logic       cy;
        logic       err;
        logic       chk_zero;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    alu_seq #(.WIDTH(W), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .selector(selector),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_hi(result_hi), .result_lo(result_lo),
        .negative(negative), .zero(zero), .carry(carry), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: compare every consumed result against the scoreboard head.
    initial begin
        exp_t  e;
        string nm;
        logic [7:0] got;
        logic ok;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_tests++;
                got = {result_hi, result_lo};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got result %0h with nothing expected", got);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    ok = (got === e.res) && (negative === e.neg) && (carry === e.cy) &&
                         (error === e.err) && (!e.chk_zero || zero === e.zr);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL %s: got res=%0h n=%0b z=%0b c=%0b e=%0b expected res=%0h n=%0b z=%0b c=%0b e=%0b",
                                 nm, got, negative, zero, carry, error,
                                 e.res, e.neg, e.zr, e.cy, e.err);
                    end
                end
            end
        end
    end

    task automatic do_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] sel, input logic [7:0] res,
                         input logic neg, input logic zr, input logic cy, input logic err,
                         input logic chkz, input int lat);
        int l;
        exp_t e;
        @(negedge clk);
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        e = '{res: res, neg: neg, zr: zr, cy: cy, err: err, chk_zero: chkz};
        exp_q.push_back(e);
        name_q.push_back(nm);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        selector = sel;
        @(posedge clk);
        l = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && l < 20) begin
            @(negedge clk);
            l++;
        end
        chk({nm, "_latency"}, l, lat);
        @(posedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        selector  = 16'h0000;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", {24'd0, result_hi, result_lo}, 32'd0);
        chk("rst_flags", {28'd0, negative, zero, carry, error}, 32'd0);
        reset = 1'b0;

        // Main function
        do_op("add_carry", 8'hF0, 8'h20, 16'h0001, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        do_op("add_wrap",  8'hFF, 8'h01, 16'h0001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        do_op("sub_neg",   8'h05, 8'h09, 16'h0002, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("sub_pos",   8'h09, 8'h05, 16'h0002, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("sub_eq",    8'h33, 8'h33, 16'h0002, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        do_op("not",       8'h5A, 8'h00, 16'h0004, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("nand",      8'hF0, 8'h3C, 16'h0008, 8'hCF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("nor",       8'hF0, 8'h3C, 16'h0010, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("and",       8'hF0, 8'h3C, 16'h0020, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("xor",       8'hF0, 8'h3C, 16'h0040, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("or",        8'hF0, 8'h3C, 16'h0080, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("xnor",      8'hF0, 8'h3C, 16'h0100, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("shl7",      8'h01, 8'h07, 16'h0400, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        do_op("shr_mask",  8'h81, 8'h0F, 16'h0800, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        do_op("mul_carry", 8'h12, 8'h34, 16'h0200, 8'hA8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9);
        do_op("mul_small", 8'h03, 8'h05, 16'h0200, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
`else
        do_op("mul_disabled", 8'h12, 8'h34, 16'h0200, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
`endif

        // Illegal selectors, then recovery
        do_op("illegal_multi", 8'h12, 8'h34, 16'h0003, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        do_op("illegal_none",  8'h12, 8'h34, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        do_op("illegal_high",  8'h12, 8'h34, 16'h1000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        do_op("shl_after_err", 8'h81, 8'h09, 16'h0400, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Backpressure: result held, new request ignored
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'hAA; b = 8'hFF; selector = 16'h0040;
        exp_q.push_back('{res: 8'h55, neg: 1'b0, zr: 1'b0, cy: 1'b0, err: 1'b0, chk_zero: 1'b1});
        name_q.push_back("xor_backpressure");
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {24'd0, result_hi, result_lo}, 32'h55);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1;
            a = 8'h01; b = 8'h01; selector = 16'h0001;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        chk("bp_still_held", {24'd0, result_hi, result_lo}, 32'h55);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while a result sits in DONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'hF0; b = 8'h20; selector = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_before_reset", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done_result", {24'd0, result_hi, result_lo}, 32'd0);
        chk("rst_done_flags", {28'd0, negative, zero, carry, error}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;

`ifdef ALU_SEQ_MUL_EN
        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h12; b = 8'h34; selector = 16'h0200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy_result", {24'd0, result_hi, result_lo}, 32'd0);
        chk("rst_busy_flags", {28'd0, negative, zero, carry, error}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
        end
        chk("rst_busy_no_output", {31'd0, out_valid}, 32'd0);
`endif

        // Service after reset
        do_op("add_after_reset", 8'h01, 8'h02, 16'h0001, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
